// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - blend modes and one-hot controller states for gfx_blend_unit
package gfx_pkg;

  typedef enum logic [1:0] {
    REPLACE = 2'd0,
    ALPHA   = 2'd1,
    ADD     = 2'd2,
    MUL     = 2'd3
  } blend_mode_e;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ALPHA = 5'b00010,
    ST_READ  = 5'b00100,
    ST_CALC  = 5'b01000,
    ST_WRITE = 5'b10000
  } state_e;

endpackage

// File: rtl/gfx_blend_unit_if.sv
// rtl/gfx_blend_unit_if.sv - render-side pixel write port of gfx_blend_unit
interface gfx_blend_unit_if
  import gfx_pkg::*;
#(
  parameter int point_width = 16,
  parameter int CW          = 8,
  parameter int NCH         = 4
);
  logic        [point_width-1:0] pixel_x_o;
  logic        [point_width-1:0] pixel_y_o;
  logic signed [point_width-1:0] pixel_z_o;
  logic        [NCH*CW-1:0]      pixel_color_o;
  logic                          write_o;
  logic                          ack_i;

  modport master (
    output pixel_x_o, pixel_y_o, pixel_z_o, pixel_color_o, write_o,
    input  ack_i
  );

  modport slave (
    input  pixel_x_o, pixel_y_o, pixel_z_o, pixel_color_o, write_o,
    output ack_i
  );
endinterface

// File: rtl/gfx_blend_channel.sv
// rtl/gfx_blend_channel.sv - one colour channel of the alpha/additive/multiply blend
module gfx_blend_channel
  import gfx_pkg::*;
#(
  parameter int CW = 8
) (
  input  blend_mode_e   mode,
  input  logic [CW-1:0] s,
  input  logic [CW-1:0] d,
  input  logic [CW-1:0] ca,
  output logic [CW-1:0] result
);
  localparam logic [CW-1:0] MAXV = '1;

  logic [2*CW-1:0] mix;
  logic [2*CW-1:0] prod;
  logic [CW:0]     sum;

  // s*ca + d*(max-ca) never exceeds max*max, so 2*CW bits hold it
  assign mix  = (2*CW)'(s) * (2*CW)'(ca) + (2*CW)'(d) * (2*CW)'(MAXV - ca);
  assign prod = (2*CW)'(s) * (2*CW)'(d);
  assign sum  = (CW+1)'(s) + (CW+1)'(d);

  always_comb begin
    result = s;
    case (mode)
      REPLACE: result = s;
      ALPHA:   result = CW'(mix >> CW);
      ADD:     result = sum[CW] ? MAXV : sum[CW-1:0];
      MUL:     result = CW'(prod >> CW);
    endcase
  end
endmodule

// File: rtl/gfx_blend_unit.sv
// rtl/gfx_blend_unit.sv - fragment blend controller: alpha, target read, blend, pixel write
// Optional GFX_BLEND_OPAQUE_BYPASS_EN: alpha-mode pixels with ca = max skip the read, ca = 0 skip the write.
module gfx_blend_unit
  import gfx_pkg::*;
#(
  parameter int point_width = 16,
  parameter int CW          = 8,
  parameter int NCH         = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    blend_mode_i,
  input  logic                          write_i,
  input  logic        [point_width-1:0] x_counter_i,
  input  logic        [point_width-1:0] y_counter_i,
  input  logic signed [point_width-1:0] z_i,
  input  logic        [NCH*CW-1:0]      pixel_color_i,
  input  logic        [CW-1:0]          alpha_i,
  input  logic        [CW-1:0]          global_alpha_i,
  output logic                          ack_o,
  output logic                          target_request_o,
  input  logic                          target_ack_i,
  input  logic        [NCH*CW-1:0]      target_color_i,
  input  logic                          wbm_busy_i,
  gfx_blend_unit_if.master              rnd
);
  state_e              state_q;
  blend_mode_e         mode_q;
  logic [NCH*CW-1:0]   src_q;
  logic [NCH*CW-1:0]   tgt_q;
  logic [CW-1:0]       alpha_q;
  logic [CW-1:0]       galpha_q;
  logic [CW-1:0]       ca_q;
  logic [CW-1:0]       ca_next;
  logic [NCH*CW-1:0]   blended;

  assign ca_next = CW'(((2*CW)'(alpha_q) * (2*CW)'(galpha_q)) >> CW);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gfx_blend_channel #(.CW(CW)) u_ch (
      .mode   (mode_q),
      .s      (src_q[g*CW +: CW]),
      .d      (tgt_q[g*CW +: CW]),
      .ca     (ca_q),
      .result (blended[g*CW +: CW])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q           <= ST_IDLE;
      mode_q            <= REPLACE;
      src_q             <= '0;
      tgt_q             <= '0;
      alpha_q           <= '0;
      galpha_q          <= '0;
      ca_q              <= '0;
      ack_o             <= 1'b0;
      target_request_o  <= 1'b0;
      rnd.write_o       <= 1'b0;
      rnd.pixel_x_o     <= '0;
      rnd.pixel_y_o     <= '0;
      rnd.pixel_z_o     <= '0;
      rnd.pixel_color_o <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (write_i) begin
            rnd.pixel_x_o <= x_counter_i;
            rnd.pixel_y_o <= y_counter_i;
            rnd.pixel_z_o <= z_i;
            src_q         <= pixel_color_i;
            alpha_q       <= alpha_i;
            galpha_q      <= global_alpha_i;
            mode_q        <= blend_mode_e'(blend_mode_i);
            if (blend_mode_e'(blend_mode_i) == REPLACE) begin
              rnd.pixel_color_o <= pixel_color_i;
              rnd.write_o       <= 1'b1;
              state_q           <= ST_WRITE;
            end else begin
              state_q <= ST_ALPHA;
            end
          end
        end
        ST_ALPHA: begin
          ca_q <= ca_next;
`ifdef GFX_BLEND_OPAQUE_BYPASS_EN
          if (mode_q == ALPHA && ca_next == '1) begin
            rnd.pixel_color_o <= src_q;
            rnd.write_o       <= 1'b1;
            state_q           <= ST_WRITE;
          end else if (mode_q == ALPHA && ca_next == '0) begin
            ack_o   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_READ;
          end
`else
          state_q <= ST_READ;
`endif
        end
        ST_READ: begin
          // an ack only completes the read once our request is actually out
          if (target_request_o) begin
            if (target_ack_i) begin
              target_request_o <= 1'b0;
              tgt_q            <= target_color_i;
              state_q          <= ST_CALC;
            end
          end else if (!wbm_busy_i) begin
            target_request_o <= 1'b1;
          end
        end
        ST_CALC: begin
          rnd.pixel_color_o <= blended;
          rnd.write_o       <= 1'b1;
          state_q           <= ST_WRITE;
        end
        ST_WRITE: begin
          if (rnd.ack_i) begin
            rnd.write_o <= 1'b0;
            ack_o       <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rnd.write_o      <= 1'b0;
          target_request_o <= 1'b0;
          state_q          <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/gfx_blend_unit.md
GFX_BLEND_UNIT -- requirements
Module: gfx_blend_unit

Interface
REQ-001 SHALL have parameter point_width, default 16, pixel coordinate width.
REQ-002 SHALL have parameter CW, default 8, bits per colour channel (4..10).
REQ-003 SHALL have parameter NCH, default 4, channel count (1..4); colour buses are NCH*CW bits, channel 0 in the LSBs.
REQ-004 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset); one clock, reset synchronous active-low.
REQ-005 SHALL have blend_mode_i (in, 2): 0 replace, 1 alpha, 2 additive, 3 multiply; sampled on accept.
REQ-006 SHALL have write_i (in, 1), x_counter_i / y_counter_i (in, point_width), z_i (in, point_width signed), pixel_color_i (in, NCH*CW), alpha_i / global_alpha_i (in, CW), ack_o (out, 1): fragment side.
REQ-007 SHALL have target_request_o (out, 1), target_ack_i (in, 1), target_color_i (in, NCH*CW), wbm_busy_i (in, 1): target reader side.
REQ-008 SHALL have pixel_x_o / pixel_y_o (out, point_width), pixel_z_o (out, point_width signed), pixel_color_o (out, NCH*CW), write_o (out, 1), ack_i (in, 1): render side.

Function
REQ-009 SHALL use states IDLE, ALPHA, READ, CALC, WRITE, one-hot.
REQ-010 IDLE: on write_i, SHALL latch coordinates, z, colour, alpha inputs and mode; mode 0 -> WRITE, else -> ALPHA.
REQ-011 ALPHA: SHALL register ca = (alpha_i*global_alpha_i) >> CW (2*CW-bit product); -> READ next cycle.
REQ-012 READ: target_request_o SHALL rise only when wbm_busy_i=0 and SHALL hold until target_ack_i; on ack, SHALL drop request, latch target_color_i, -> CALC.
REQ-013 CALC: per channel s (source), d (target): alpha = (s*ca + d*(2^CW-1-ca)) >> CW; additive = min(s+d, 2^CW-1); multiply = (s*d) >> CW; result registered to pixel_color_o; -> WRITE.
REQ-014 Mode 0 SHALL pass pixel_color_i unchanged, with no target read.
REQ-015 WRITE: write_o SHALL be high, pixel_*_o stable, until the cycle ack_i=1; then write_o=0, ack_o pulses one cycle, -> IDLE.
REQ-016 write_i SHALL be ignored outside IDLE; ack_i outside WRITE and target_ack_i outside READ SHALL be ignored.
REQ-017 Latency write_i->write_o: mode 0 = 1 cycle; modes 1-3 = 3 cycles plus read wait.
REQ-018 Any illegal state encoding SHALL return to IDLE next cycle.

Reset
REQ-019 rst_ni=0 at a clock edge SHALL force IDLE, ack_o=0, write_o=0, target_request_o=0, pixel_x_o/y_o/z_o=0, pixel_color_o=0, aborting any transaction mid-flight including an outstanding read.

Configuration
REQ-020 With GFX_BLEND_OPAQUE_BYPASS_EN defined, mode 1 with ca = 2^CW-1 after ALPHA SHALL skip READ/CALC and write pixel_color_i directly (-> WRITE), and ca = 0 SHALL skip the write entirely (ack_o pulses, -> IDLE).
REQ-021 Without GFX_BLEND_OPAQUE_BYPASS_EN, every mode 1-3 pixel SHALL perform the target read and write.

Structure
REQ-022 blend_mode_e enum (REPLACE, ALPHA, ADD, MUL) and the state encoding SHALL live in gfx_pkg.
REQ-023 Per-channel arithmetic SHALL be a sub-module gfx_blend_channel (parameter CW), instantiated NCH times via generate.

Verification
REQ-024 CW=8, NCH=4, mode 0, colour 0x11223344, ack_i after 2 cycles -> write_o one cycle after write_i, pixel_color_o=0x11223344, no target_request_o, one ack_o pulse.
REQ-025 Mode 1, alpha_i=0x80, global=0xFF, s=0xFF, d=0x00 per channel -> ca=0x7F, each output channel 0x7E.
REQ-026 Mode 2, s=0xF0, d=0x20 -> 0xFF (saturated); mode 3, s=0x80, d=0x80 -> 0x40.
REQ-027 Mode 1, wbm_busy_i=1 for 5 cycles -> target_request_o stays 0, rises the cycle after busy drops, held until target_ack_i.
REQ-028 rst_ni=0 while in READ with request high -> next cycle all outputs zero, state IDLE; a later target_ack_i is ignored.
REQ-029 With GFX_BLEND_OPAQUE_BYPASS_EN: alpha 0xFF/0xFF -> ca=0xFE, read performed; CW=4, alpha 0xF/0xF -> ca=0xE, read performed; alpha_i=0 -> no request, no write_o, ack_o pulse.
